// File: rtl/dot_accum_pkg.sv
// rtl/dot_accum_pkg.sv - shared state encoding and default widths for dot_accum
package dot_accum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int PROD_W_D = 16;
    localparam int ACC_W_D  = 24;
    localparam int CNT_W_D  = 8;

endpackage

// File: rtl/dot_accum.sv
// rtl/dot_accum.sv - frame accumulator summing multiplier products, result on valid/ready
// Optional macro DOT_ACCUM_SAT_EN: clamp the sum at all-ones after overflow instead of wrapping.
module dot_accum
    import dot_accum_pkg::*;
#(
    parameter int PROD_W = PROD_W_D,
    parameter int ACC_W  = ACC_W_D,
    parameter int CNT_W  = CNT_W_D
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;

    logic               accept;
    logic [ACC_W:0]     sum_ext;
    logic [ACC_W-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt_next;
    logic               ovf_next;

    // in_ready comes only from registered state, never from out_ready.
    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;

    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

    always_comb begin
        sum_ext  = {1'b0, acc_q} + (ACC_W+1)'(in_prod);
        ovf_next = ovf_q | sum_ext[ACC_W];
`ifdef DOT_ACCUM_SAT_EN
        acc_next = ovf_next ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
        acc_next = sum_ext[ACC_W-1:0];
`endif
        cnt_next = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    acc_d = acc_next;
                    cnt_d = cnt_next;
                    ovf_d = ovf_next;
                    if (in_last) begin
                        state_d     = HOLD;
                        out_sum_d   = acc_next;
                        out_count_d = cnt_next;
                        out_ovf_d   = ovf_next;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: doc/dot_accum.md
Name: dot_accum

Overview:
- Downstream consumer of the 8x8 unsigned multiplier stage. Takes a stream of 16-bit unsigned products and accumulates them into a wider sum over a frame delimited by `in_last`.
- Presents the frame sum and beat count on a valid/ready output.
- Together with the multiplier, forms the dot-product datapath: the multiplier supplies A*X, this block supplies the sum of A*X.

Parameters:
- PROD_W, 16, width of incoming product
- ACC_W, 24, accumulator and result width (must be >= PROD_W)
- CNT_W, 8, beat-count width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  product beat valid
- in_ready  output  1  block can accept a beat
- in_prod  input  PROD_W  unsigned product from multiplier
- in_last  input  1  beat is the final one of the frame
- out_valid  output  1  frame result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  ACC_W  frame sum
- out_count  output  CNT_W  beats in frame, saturating
- out_ovf  output  1  sum exceeded 2^ACC_W-1 during frame (sticky per frame)

Behaviour:
- Single clock `clk`; reset is asynchronous and active-low on `rst_n`.
- Reset values: state IDLE, acc=0, count=0, ovf=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0, in_ready=1.
- States and transitions:
  - IDLE: no beats accepted. Accept w/o last -> ACC. Accept with last -> HOLD.
  - ACC: at least 1 beat accepted. Accept w/o last -> stay. Accept with last -> HOLD.
  - HOLD: result presented. out_valid && out_ready -> IDLE.
- Accept condition: in_valid && in_ready. in_ready = (state != HOLD), registered-state-derived; no combinational path from out_ready to in_ready.
- Arithmetic:
  - Accept: acc <= acc + zero-extend(in_prod).
  - Carry out of bit ACC_W-1 sets ovf.
  - Sum wraps modulo 2^ACC_W.
- Count: count <= count+1 on accept, saturating at 2^CNT_W-1.
- Last beat:
  - out_sum, out_count, out_ovf load the post-add values (including the last beat) on the accepting edge.
  - out_valid rises the next cycle. Latency = 1 clock from last-beat acceptance.
- HOLD:
  - out_sum/out_count/out_ovf/out_valid held stable while out_ready=0.
  - On handshake: acc, count, ovf cleared; out_valid drops next cycle; in_ready reasserts the same next cycle.
  - out_sum/out_count/out_ovf retain their last values after the handshake (don't-care when out_valid=0).
- Single-beat frame (in_last on first beat): out_sum = in_prod, out_count = 1.
- in_valid=0 gaps mid-frame: no change.
- in_prod/in_last are ignored when not accepted.
- Reset asserted mid-frame or in HOLD: immediately returns to reset values; the partial frame is discarded.
- Zero products are counted as beats.

Optional Feature:
- Macro: DOT_ACCUM_SAT_EN
- Defined: on overflow, acc clamps to 2^ACC_W-1 and stays there for the rest of the frame; ovf is still set.
- Undefined: wrap modulo 2^ACC_W as above.

Decomposition:
- Package `dot_accum_pkg`: state enum (IDLE, ACC, HOLD), default width constants PROD_W_D=16, ACC_W_D=24, CNT_W_D=8.
- No sub-module: adder, counter and FSM fit in one module.

Test Plan:
- Frame of 3 beats 100, 200, 300 (last on 300), out_ready=1 -> out_valid 1 clk later, out_sum=600, out_count=3, out_ovf=0, in_ready low exactly 1 cycle.
- Single beat 65025 with in_last -> out_sum=65025, out_count=1.
- 258 beats of 65025 -> out_sum=16,776,450, out_count=255 (saturated), out_ovf=0.
- 259 beats of 65025 -> out_ovf=1, out_count=255, and either:
  - without macro: out_sum=64,259
  - with DOT_ACCUM_SAT_EN: out_sum=16,777,215
- Backpressure: frame {10,20}, out_ready=0 for 5 cycles -> out_valid=1 and out_sum=30 stable for all 5 cycles, in_ready=0, offered beats not accepted. Then out_ready=1 -> in_ready=1 next cycle; a next frame {7} gives out_sum=7.
- rst_n pulsed low after 2 beats of 500 -> outputs at reset values. A following frame {1,2,3} gives out_sum=6, out_count=3.
